// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: shares the single write port between MW writeback
// and a long-latency unit (via a small in-order FIFO) and tracks registers it still owes.
module wb_port_arbiter #(
  parameter int BUF_DEPTH    = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        wb_valid_i,
  input  logic [4:0]  wb_rdId_i,
  input  logic [31:0] wb_data_i,
  output logic        wb_stall_o,
  input  logic        lu_issue_i,
  input  logic [4:0]  lu_issueRd_i,
  input  logic        lu_valid_i,
  input  logic [4:0]  lu_rdId_i,
  input  logic [31:0] lu_data_i,
  output logic        lu_ready_o,
  output logic [4:0]  rdId_o,
  output logic [31:0] rdData_o,
  output logic [31:0] busy_o,
  output logic        err_o
);

  localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CNT_W = $clog2(BUF_DEPTH + 1);
  localparam int STV_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(BUF_DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(BUF_DEPTH - 1);
  localparam logic [STV_W-1:0] STARVE_C = STV_W'(STARVE_LIMIT);

  logic [4:0]       fifo_rd_mem   [BUF_DEPTH];
  logic [31:0]      fifo_data_mem [BUF_DEPTH];

  logic [PTR_W-1:0] head_reg, head_next;
  logic [PTR_W-1:0] tail_reg, tail_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic [STV_W-1:0] starve_reg, starve_next;
  logic [31:0]      busy_reg, busy_next;
  logic             err_reg, err_next;

  logic        fifo_nonempty;
  logic        lu_ready;
  logic        lu_hs;
  logic        wb_eff;
  logic        force_drain;
  logic [4:0]  head_rd;
  logic [31:0] head_data;

  logic [4:0]  sel_rd;
  logic [31:0] sel_data;
  logic        sel_stall;
  logic        pop;
  logic        push;
  logic        bypass;
  logic        wb_win;
  logic        lu_write;

  logic [31:0] set_vec;
  logic [31:0] clr_vec;

  logic        err_waw;
  logic        err_orphan;
  logic        err_double;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  assign fifo_nonempty = (count_reg != '0);
  assign lu_ready      = reset_i & (count_reg < DEPTH_C);
  assign lu_hs         = lu_valid_i & lu_ready;
  // A pipeline writeback to x0 carries no data, so it must not block a FIFO drain.
  assign wb_eff        = wb_valid_i & (wb_rdId_i != 5'd0);
  assign force_drain   = (starve_reg == STARVE_C) & fifo_nonempty;
  assign head_rd       = fifo_rd_mem[head_reg];
  assign head_data     = fifo_data_mem[head_reg];

  always_comb begin
    sel_rd    = 5'd0;
    sel_data  = 32'd0;
    sel_stall = 1'b0;
    pop       = 1'b0;
    bypass    = 1'b0;
    wb_win    = 1'b0;
    lu_write  = 1'b0;
    if (force_drain) begin
      sel_rd    = head_rd;
      sel_data  = head_data;
      sel_stall = 1'b1;
      pop       = 1'b1;
      lu_write  = 1'b1;
    end else if (wb_eff) begin
      sel_rd    = wb_rdId_i;
      sel_data  = wb_data_i;
      wb_win    = 1'b1;
    end else if (fifo_nonempty) begin
      sel_rd    = head_rd;
      sel_data  = head_data;
      pop       = 1'b1;
      lu_write  = 1'b1;
    end else if (lu_hs) begin
      sel_rd    = lu_rdId_i;
      sel_data  = lu_data_i;
      bypass    = 1'b1;
      lu_write  = 1'b1;
    end
  end

  assign push = lu_hs & ~bypass;

  always_comb begin
    head_next  = pop  ? ptr_inc(head_reg) : head_reg;
    tail_next  = push ? ptr_inc(tail_reg) : tail_reg;
    count_next = count_reg + CNT_W'(push) - CNT_W'(pop);
    starve_next = starve_reg;
    if (pop || !fifo_nonempty) begin
      starve_next = '0;
    end else if (wb_win && (starve_reg != STARVE_C)) begin
      starve_next = starve_reg + STV_W'(1);
    end
  end

  // Scoreboard: per-register set/clear, set wins when both hit the same bit.
  generate
    for (genvar gi = 0; gi < 32; gi++) begin : g_busy
      if (gi == 0) begin : g_x0
        assign set_vec[gi]   = 1'b0;
        assign clr_vec[gi]   = 1'b0;
        assign busy_next[gi] = 1'b0;
      end else begin : g_xn
        assign set_vec[gi]   = lu_issue_i & (lu_issueRd_i == 5'(gi));
        assign clr_vec[gi]   = lu_write & (sel_rd == 5'(gi));
        assign busy_next[gi] = set_vec[gi] | (busy_reg[gi] & ~clr_vec[gi]);
      end
    end
  endgenerate

  assign err_waw    = wb_win & busy_reg[wb_rdId_i];
  assign err_orphan = lu_write & (sel_rd != 5'd0) & ~busy_reg[sel_rd];
  // Re-issuing to a register whose result is retiring this very cycle is legitimate.
  assign err_double = lu_issue_i & (lu_issueRd_i != 5'd0)
                    & busy_reg[lu_issueRd_i] & ~clr_vec[lu_issueRd_i];
  assign err_next   = err_reg | err_waw | err_orphan | err_double;

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      head_reg   <= '0;
      tail_reg   <= '0;
      count_reg  <= '0;
      starve_reg <= '0;
      busy_reg   <= '0;
      err_reg    <= 1'b0;
    end else begin
      head_reg   <= head_next;
      tail_reg   <= tail_next;
      count_reg  <= count_next;
      starve_reg <= starve_next;
      busy_reg   <= busy_next;
      err_reg    <= err_next;
    end
  end

  // Payload storage needs no reset: validity is tracked entirely by count_reg.
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_rd_mem[tail_reg]   <= lu_rdId_i;
      fifo_data_mem[tail_reg] <= lu_data_i;
    end
  end

  assign lu_ready_o = lu_ready;
  assign wb_stall_o = reset_i & sel_stall;
  assign rdId_o     = reset_i ? sel_rd : 5'd0;
  assign rdData_o   = sel_data;
  assign busy_o     = busy_reg;
  assign err_o      = err_reg;

endmodule
